// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the 1RW SRAM request controller.
//   state_t   : controller FSM states (zero-fill, then normal operation)
//   cnt_w()   : width of a 0..depth occupancy counter
package sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default response buffer depth and the matching occupancy counter width.
  localparam int RESP_DEPTH_DEF = 3;
  localparam int RESP_CNT_W_DEF = $clog2(RESP_DEPTH_DEF + 1);

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Registered synchronous FIFO that buffers SRAM read data.
//   clk, rst_n      : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data : write one entry
//   pop, pop_data   : head entry is always presented on pop_data; pop removes it
//   full, empty     : occupancy flags
//   count           : number of entries held (0..RESP_DEPTH)
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int BITS       = 64,
  parameter int RESP_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [BITS-1:0]              push_data,
  input  logic                         pop,
  output logic [BITS-1:0]              pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [cnt_w(RESP_DEPTH)-1:0] count
);

  localparam int CW    = cnt_w(RESP_DEPTH);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

  logic [BITS-1:0]  mem [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CW'(RESP_DEPTH));
  // Head is read straight from storage; it cannot change until popped.
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Requester-side controller for a single-port 1RW SRAM macro.
// Converts a valid/ready request stream into macro cycles and returns read
// data, in order, on a valid/ready response stream. Optionally zero-fills
// the whole array after reset before accepting requests.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_addr/req_we/req_wdata/req_wmask : request payload (wmask 1 = write bit)
//   resp_valid/resp_ready/resp_rdata : read response handshake and data
//   init_done                        : high once normal operation has begun
//   sram_ce/we/addr/wd/wmask         : macro control, sampled by macro at posedge
//   sram_rd                          : macro read data, valid the cycle after a read
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 16384,
  parameter int ADDR_WIDTH = 14,
  parameter int RESP_DEPTH = 3,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BITS-1:0]       resp_rdata,
  output logic                  init_done,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam int CW = cnt_w(RESP_DEPTH);
  localparam int UW = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(WORD_DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_inflight;
  logic [CW-1:0]         buf_count;
  logic                  buf_full;
  logic                  buf_empty;
  logic                  resp_pop;
  logic [UW-1:0]         used;
  logic                  fire;

  // Credits come only from registered occupancy, so resp_ready never
  // reaches req_ready combinationally.
  assign used      = {1'b0, buf_count} + UW'(rd_inflight);
  // rst_n gating keeps the handshake and macro strobes quiet while reset is
  // held, whatever state the FSM resets into.
  assign req_ready = rst_n && (state == ST_RUN) && (used < UW'(RESP_DEPTH));
  assign fire      = req_valid && req_ready;

  assign resp_valid = !buf_empty;
  assign resp_pop   = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      init_cnt    <= '0;
      init_done   <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          rd_inflight <= 1'b0;
          if (init_cnt == INIT_LAST) begin
            state     <= ST_RUN;
            init_cnt  <= '0;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          init_done   <= 1'b1;
          rd_inflight <= fire && !req_we;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = req_addr;
    sram_wd    = req_wdata;
    sram_wmask = req_wmask;
    if (state == ST_INIT) begin
      sram_ce    = rst_n;
      sram_we    = rst_n;
      sram_addr  = init_cnt;
      sram_wd    = '0;
      sram_wmask = '1;
    end else begin
      sram_ce = fire;
      sram_we = fire && req_we;
    end
  end

  sram_resp_fifo #(
    .BITS       (BITS),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_inflight),
    .push_data (sram_rd),
    .pop       (resp_pop),
    .pop_data  (resp_rdata),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // The credit rule must make a push into a full, non-draining buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_inflight && buf_full && !resp_pop));

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
module tb_sram_1rw_req_ctrl;

  localparam int BITS = 64;
  localparam int WD   = 16;
  localparam int AW   = 4;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_we;
  logic [BITS-1:0] req_wdata;
  logic [BITS-1:0] req_wmask;
  logic            resp_valid;
  logic            resp_ready;
  logic [BITS-1:0] resp_rdata;
  logic            init_done;
  logic            sram_ce;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [BITS-1:0] sram_wd;
  logic [BITS-1:0] sram_wmask;
  logic [BITS-1:0] sram_rd;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  logic [BITS-1:0] rx_data [$];
  int              rx_cyc  [$];
  int              fire_cyc[$];

  sram_1rw_req_ctrl #(
    .BITS       (BITS),
    .WORD_DEPTH (WD),
    .ADDR_WIDTH (AW),
    .RESP_DEPTH (3),
    .INIT_ZERO  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wd    (sram_wd),
    .sram_wmask (sram_wmask),
    .sram_rd    (sram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 1RW macro: masked write, read data one cycle later.
  logic [BITS-1:0] mem [WD];
  logic [BITS-1:0] rd_q;
  initial begin
    for (int i = 0; i < WD; i++) mem[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
    rd_q = '0;
  end
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
      else         rd_q <= mem[sram_addr];
    end
  end
  assign sram_rd = rd_q;

  // Response monitor: records each accepted response and its cycle.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      rx_data.push_back(resp_rdata);
      rx_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers (no checking inside except expired bounds) ----
  task automatic do_req(input logic we, input logic [AW-1:0] a,
                        input logic [BITS-1:0] d, input logic [BITS-1:0] m);
    int k;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    asserts++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic stream_reads(input int n, input int base, input int budget);
    int issued;
    int k;
    fire_cyc.delete();
    req_we = 1'b0; req_valid = 1'b1; req_addr = AW'(base);
    issued = 0; k = 0;
    while (issued < n && k < budget) begin
      @(negedge clk);
      if (req_ready) begin
        fire_cyc.push_back(cyc);
        issued++;
      end
      @(posedge clk); #1;
      req_addr = AW'(base + issued);
      if (issued == n) req_valid = 1'b0;
      k++;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_data.size() < n && k < budget) begin
      @(posedge clk); #1; k++;
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
    #2;
    asserts++;
    if ({req_ready, resp_valid, init_done, sram_ce, sram_we} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: ready/rvalid/done/ce/we=%b required 00000",
               {req_ready, resp_valid, init_done, sram_ce, sram_we});
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_init();
    logic [AW+2+2*BITS+1:0] got, exp;
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < WD; i++) begin
      got = {sram_ce, sram_we, sram_addr, sram_wd, sram_wmask, req_ready, init_done};
      exp = {1'b1, 1'b1, AW'(i), 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      asserts++;
      if (got !== exp) begin
        fails++;
        $display("FAIL init_cycle%0d: ce=%b we=%b addr=%0d wd=%h mask=%h rdy=%b done=%b required ce=1 we=1 addr=%0d wd=0 mask=all-1 rdy=0 done=0",
                 i, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask, req_ready, init_done, i);
      end
      @(posedge clk); #1;
    end
    asserts++;
    if ({init_done, req_ready} !== 2'b11) begin
      fails++;
      $display("FAIL init_done_cycle17: done=%b ready=%b required 1 1", init_done, req_ready);
    end
  endtask

  task automatic test_init_reads();
    rx_data.delete(); rx_cyc.delete();
    resp_ready = 1'b1;
    stream_reads(16, 0, 100);
    wait_rx(16, 50);
    asserts++;
    if (rx_data.size() != 16) begin
      fails++;
      $display("FAIL init_reads_count: got %0d responses required 16", rx_data.size());
    end
    for (int i = 0; i < 16; i++) begin
      asserts++;
      if (rx_data[i] !== 64'h0) begin
        fails++;
        $display("FAIL init_read_addr%0d: rdata=%h required 0", i, rx_data[i]);
      end
    end
  endtask

  task automatic test_write_read();
    resp_ready = 1'b1;
    do_req(1'b1, 4'd5, 64'hDEAD_BEEF_0BAD_F00D, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 4'd5, '0, '0);
    asserts++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_latency_t1: resp_valid=%b required 0", resp_valid);
    end
    @(posedge clk); #1;
    asserts++;
    if (resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rd_latency_t2: resp_valid=%b required 1", resp_valid);
    end
    asserts++;
    if (resp_rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin
      fails++;
      $display("FAIL write_read_data: rdata=%h required DEADBEEF0BADF00D", resp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_masked_write();
    resp_ready = 1'b1;
    do_req(1'b1, 4'd5, 64'h0, 64'h0000_0000_FFFF_FFFF);
    do_req(1'b0, 4'd5, '0, '0);
    @(posedge clk); #1;
    asserts++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'hDEAD_BEEF_0000_0000) begin
      fails++;
      $display("FAIL masked_write: valid=%b rdata=%h required 1 DEADBEEF00000000",
               resp_valid, resp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    for (int i = 8; i < 16; i++)
      do_req(1'b1, AW'(i), 64'hC0DE_0000_0000_0000 | 64'(i), 64'hFFFF_FFFF_FFFF_FFFF);
    rx_data.delete(); rx_cyc.delete();
    stream_reads(8, 8, 40);
    wait_rx(8, 20);
    asserts++;
    if (fire_cyc.size() != 8 || rx_data.size() != 8) begin
      fails++;
      $display("FAIL stream_counts: fires=%0d resps=%0d required 8 8", fire_cyc.size(), rx_data.size());
    end else begin
      asserts++;
      if (fire_cyc[7] - fire_cyc[0] != 7) begin
        fails++;
        $display("FAIL stream_fire_bubbles: span=%0d required 7", fire_cyc[7] - fire_cyc[0]);
      end
      asserts++;
      if (rx_cyc[7] - rx_cyc[0] != 7) begin
        fails++;
        $display("FAIL stream_resp_bubbles: span=%0d required 7", rx_cyc[7] - rx_cyc[0]);
      end
      asserts++;
      if (rx_cyc[0] - fire_cyc[0] != 2) begin
        fails++;
        $display("FAIL stream_latency: %0d required 2", rx_cyc[0] - fire_cyc[0]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      asserts++;
      if (rx_data[i] !== (64'hC0DE_0000_0000_0000 | 64'(i + 8))) begin
        fails++;
        $display("FAIL stream_data%0d: rdata=%h required %h", i, rx_data[i],
                 64'hC0DE_0000_0000_0000 | 64'(i + 8));
      end
    end
  endtask

  task automatic test_backpressure();
    int fires;
    int k;
    rx_data.delete(); rx_cyc.delete();
    resp_ready = 1'b0;
    fires = 0;
    req_we = 1'b0; req_valid = 1'b1; req_addr = 4'd8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready) fires++;
      @(posedge clk); #1;
      req_addr = AW'(8 + fires);
    end
    asserts++;
    if (fires != 3) begin
      fails++;
      $display("FAIL bp_fire_count: fires=%0d required 3", fires);
    end
    asserts++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_stall: req_ready=%b resp_valid=%b required 0 1", req_ready, resp_valid);
    end
    asserts++;
    if (resp_rdata !== 64'hC0DE_0000_0000_0008) begin
      fails++;
      $display("FAIL bp_hold_data: rdata=%h required C0DE000000000008", resp_rdata);
    end
    resp_ready = 1'b1;
    k = 0;
    while (fires < 6 && k < 30) begin
      @(negedge clk);
      if (req_ready) fires++;
      @(posedge clk); #1;
      req_addr = AW'(8 + fires);
      if (fires == 6) req_valid = 1'b0;
      k++;
    end
    req_valid = 1'b0;
    asserts++;
    if (fires != 6) begin
      fails++;
      $display("FAIL bp_resume: fires=%0d required 6", fires);
    end
    wait_rx(6, 20);
    for (int i = 0; i < 6; i++) begin
      asserts++;
      if (rx_data[i] !== (64'hC0DE_0000_0000_0000 | 64'(i + 8))) begin
        fails++;
        $display("FAIL bp_order%0d: rdata=%h required %h", i, rx_data[i],
                 64'hC0DE_0000_0000_0000 | 64'(i + 8));
      end
    end
  endtask

  task automatic test_reset_midop();
    int fires;
    int k;
    rx_data.delete(); rx_cyc.delete();
    resp_ready = 1'b0;
    fires = 0; k = 0;
    req_we = 1'b0; req_valid = 1'b1; req_addr = 4'd8;
    while (fires < 3 && k < 10) begin
      @(negedge clk);
      if (req_ready) fires++;
      @(posedge clk); #1;
      req_addr = AW'(8 + fires);
      k++;
    end
    req_valid = 1'b0;
    asserts++;
    if (fires != 3 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL midop_setup: fires=%0d resp_valid=%b req_ready=%b required 3 1 0",
               fires, resp_valid, req_ready);
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({resp_valid, req_ready, sram_ce, init_done} !== 4'b0) begin
      fails++;
      $display("FAIL midop_async_clear: rvalid/ready/ce/done=%b required 0000",
               {resp_valid, req_ready, sram_ce, init_done});
    end
    @(posedge clk); #1;
    asserts++;
    if ({resp_valid, req_ready} !== 2'b0) begin
      fails++;
      $display("FAIL midop_next_cycle: rvalid/ready=%b required 00", {resp_valid, req_ready});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    asserts++;
    if (sram_ce !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 4'd0) begin
      fails++;
      $display("FAIL midop_init_restart: ce=%b we=%b addr=%0d required 1 1 0", sram_ce, sram_we, sram_addr);
    end
    @(posedge clk); #1;
    asserts++;
    if (sram_addr !== 4'd1) begin
      fails++;
      $display("FAIL midop_init_addr1: addr=%0d required 1", sram_addr);
    end
    k = 0;
    while (!init_done && k < 40) begin
      @(posedge clk); #1; k++;
    end
    asserts++;
    if (init_done !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL midop_reinit: init_done=%b resp_valid=%b required 1 0", init_done, resp_valid);
    end
    resp_ready = 1'b1;
    do_req(1'b0, 4'd9, '0, '0);
    wait_rx(1, 10);
    asserts++;
    if (rx_data.size() != 1 || rx_data[0] !== 64'h0) begin
      fails++;
      $display("FAIL midop_refill_read: resps=%0d rdata=%h required 1 0", rx_data.size(), rx_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_init_reads();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
